core_memory_arbiter: RTL and testbench

// - Shares one single-port memory between the core's instruction bus and data bus.
// - Sits between the five-stage core and the unified RAM/peripheral port.
// - Holds a one-entry fetch buffer so a fetched word survives core stalls.
// - Grants data accesses first, with a starvation limit that protects instruction fetch.

---
 rtl/core_memory_arbiter_pkg.sv | 16 +
 rtl/core_memory_arbiter_if.sv | 26 ++
 rtl/core_memory_arbiter_fetch_buffer.sv | 60 ++++++
 rtl/core_memory_arbiter.sv | 159 +++++++++++++++
 tb/tb_core_memory_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_memory_arbiter_pkg.sv
// Shared definitions for the core memory arbiter slice.
// - Default bus widths and starvation limit used as parameter defaults.
// - Arbiter FSM state encoding.
package core_memory_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH   = 32;
    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_WAIT = 2'd1,
        DATA_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/core_memory_arbiter_if.sv
// Unified memory port between the arbiter and the RAM/peripheral side.
// - master : arbiter; drives mem_read/mem_write/mem_address/mem_write_data.
// - slave  : memory;  drives mem_read_data and the one-cycle mem_response pulse.
interface core_memory_arbiter_if
    import core_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_response;

    modport master (
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_response
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_response
    );
endinterface

// File: rtl/core_memory_arbiter_fetch_buffer.sv
// One-entry instruction fetch buffer.
// - clk, reset   : clock, synchronous active-high reset
// - pc           : current core PC, compared against the stored address
// - fill         : load fill_addr/fill_data and mark the entry valid
// - inval        : a store is being granted to inval_addr
// - hit          : entry valid and its address equals pc
// - data         : stored instruction word
module core_memory_arbiter_fetch_buffer
    import core_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fill,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  inval,
    input  logic [ADDR_WIDTH-1:0] inval_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data
);
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    always_comb begin
        // NOTE: every signal written here is defaulted first; a branch that skips one would infer a latch.
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end else if (inval && (inval_addr == addr_q)) begin
            // A store to the buffered address makes the held word stale.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            // NOTE: the data word is reset as well because it drives instruction_data directly.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && (addr_q == pc);
    assign data = data_q;
endmodule

// File: rtl/core_memory_arbiter.sv
// Shares one single-port memory between the core's instruction and data buses.
// - clk, reset                    : clock, synchronous active-high reset
// - instruction_address           : core PC; fetched whenever the buffer misses it
// - instruction_data/_response    : buffered word, valid while the buffer hits the PC
// - data_memory_read/_write       : level load/store request, held until response
// - data_address, write_data      : load/store address and store data
// - read_data                     : load result, held after the response pulse
// - data_memory_response          : one-cycle completion pulse for data accesses
// - mem                           : registered command port to the unified memory
// Data wins arbitration until STARVE_LIMIT consecutive data grants have been
// given while a fetch waits; the fetch is then forced through.
module core_memory_arbiter
    import core_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [DATA_WIDTH-1:0] instruction_data,
    output logic                  instruction_response,
    input  logic                  data_memory_read,
    input  logic                  data_memory_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  data_memory_response,
    core_memory_arbiter_if.master mem
);
    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  data_resp_q, data_resp_d;

    logic buf_hit, buf_fill, buf_inval;
    logic fetch_need, data_req;

    // During an instruction fetch mem_address_q holds the fetch address, so it
    // also serves as the address written into the buffer on completion.
    core_memory_arbiter_fetch_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .pc         (instruction_address),
        .fill       (buf_fill),
        .fill_addr  (mem_address_q),
        .fill_data  (mem.mem_read_data),
        .inval      (buf_inval),
        .inval_addr (data_address),
        .hit        (buf_hit),
        .data       (instruction_data)
    );

    assign fetch_need = ~buf_hit;
    assign data_req   = data_memory_read | data_memory_write;

    always_comb begin
        state_d          = state_q;
        starve_d         = starve_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        read_data_d      = read_data_q;
        data_resp_d      = 1'b0;
        buf_fill         = 1'b0;
        buf_inval        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // In the response-pulse cycle the core's request is still the
                // one just served, so nothing is granted in that cycle.
                if (!data_resp_q) begin
                    if (data_req && (!fetch_need || (starve_q < STARVE_MAX))) begin
                        // Read and write together is treated as a write.
                        mem_write_d      = data_memory_write;
                        mem_read_d       = ~data_memory_write;
                        mem_address_d    = data_address;
                        mem_write_data_d = write_data;
                        buf_inval        = data_memory_write;
                        state_d          = DATA_WAIT;
                        if (fetch_need) begin
                            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
                        end else begin
                            starve_d = '0;
                        end
                    end else if (fetch_need) begin
                        mem_read_d    = 1'b1;
                        mem_write_d   = 1'b0;
                        mem_address_d = instruction_address;
                        state_d       = INST_WAIT;
                        starve_d      = '0;
                    end
                end
            end
            INST_WAIT: begin
                // A PC redirect mid-fetch still completes; the stale word simply never matches.
                if (mem.mem_response) begin
                    mem_read_d = 1'b0;
                    buf_fill   = 1'b1;
                    state_d    = IDLE;
                end
            end
            DATA_WAIT: begin
                if (mem.mem_response) begin
                    if (!mem_write_q) begin
                        read_data_d = mem.mem_read_data;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    data_resp_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            starve_q         <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            read_data_q      <= '0;
            data_resp_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            starve_q         <= starve_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            read_data_q      <= read_data_d;
            data_resp_q      <= data_resp_d;
        end
    end

    assign instruction_response = buf_hit;
    assign read_data            = read_data_q;
    assign data_memory_response = data_resp_q;
    assign mem.mem_read         = mem_read_q;
    assign mem.mem_write        = mem_write_q;
    assign mem.mem_address      = mem_address_q;
    assign mem.mem_write_data   = mem_write_data_q;
endmodule

// File: tb/tb_core_memory_arbiter.sv
// Self-checking bench for core_memory_arbiter: a table of directed request
// patterns plus hand-written sequences for starvation, PC redirect mid-fetch
// and reset during a data access.
module tb_core_memory_arbiter;
    localparam logic [32:0] NONE = {1'b1, 32'hFFFF_FFFF};

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc    = '0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] instruction_data;
    logic        instruction_response;
    logic [31:0] read_data;
    logic        data_memory_response;

    core_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    core_memory_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_address  (pc),
        .instruction_data     (instruction_data),
        .instruction_response (instruction_response),
        .data_memory_read     (rd),
        .data_memory_write    (wr),
        .data_address         (daddr),
        .write_data           (wdata),
        .read_data            (read_data),
        .data_memory_response (data_memory_response),
        .mem                  (mem_if)
    );

    initial forever #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] ram [logic [31:0]];
    int          lat        = 1;
    bit          mem_auto   = 1'b1;
    int          inject_req = 0;
    int          inject_ack = 0;
    int          mcnt       = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0040: return 32'h0000_0517;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (mem_if.mem_response === 1'b1) begin
                mem_if.mem_response = 1'b0;
            end else begin
                mem_if.mem_response = 1'b0;
                if (inject_req != inject_ack) begin
                    inject_ack              = inject_req;
                    mem_if.mem_response     = 1'b1;
                    mem_if.mem_read_data    = 32'hBADB_AD00;
                end else if (!mem_auto) begin
                    mcnt = 0;
                end else if (mem_if.mem_read === 1'b1 || mem_if.mem_write === 1'b1) begin
                    mcnt++;
                    if (mcnt >= lat) begin
                        mcnt = 0;
                        mem_if.mem_response = 1'b1;
                        if (mem_if.mem_write) begin
                            ram[mem_if.mem_address] = mem_if.mem_write_data;
                        end else if (ram.exists(mem_if.mem_address)) begin
                            mem_if.mem_read_data = ram[mem_if.mem_address];
                        end else begin
                            mem_if.mem_read_data = init_word(mem_if.mem_address);
                        end
                    end
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          n_dresp = 0;
    int          n_ilow  = 0;
    logic        cmd_prev = 1'b0;
    logic [32:0] cmds[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next negedge and record what the DUT shows there.
    task automatic tick();
        logic cmd_now;
        @(negedge clk);
        cmd_now = mem_if.mem_read | mem_if.mem_write;
        if (cmd_now === 1'b1 && cmd_prev !== 1'b1) begin
            cmds.push_back({mem_if.mem_write, mem_if.mem_address});
        end
        cmd_prev = cmd_now;
        if (data_memory_response === 1'b1) n_dresp++;
        if (instruction_response !== 1'b1) n_ilow++;
    endtask

    function automatic logic [32:0] rcmd(input logic [31:0] a);
        return {1'b0, a};
    endfunction

    function automatic logic [32:0] wcmd(input logic [31:0] a);
        return {1'b1, a};
    endfunction

    function automatic logic [32:0] cmd_at(input int i);
        if (i < cmds.size()) return cmds[i];
        return NONE;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic        wr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [32:0] exp_cmd0;
        logic [32:0] exp_cmd1;
        int          exp_ndresp;
        int          exp_nilow;
        logic        exp_iresp;
        logic [31:0] exp_idata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int idx, input vec_t v);
        cmds.delete();
        n_dresp = 0;
        n_ilow  = 0;
        pc    = v.pc;
        rd    = v.rd;
        wr    = v.wr;
        daddr = v.daddr;
        wdata = v.wdata;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (data_memory_response === 1'b1) begin
                rd = 1'b0;
                wr = 1'b0;
            end
        end
        check($sformatf("v%0d_cmd0", idx),   64'(cmd_at(0)), 64'(v.exp_cmd0));
        check($sformatf("v%0d_cmd1", idx),   64'(cmd_at(1)), 64'(v.exp_cmd1));
        check($sformatf("v%0d_ndresp", idx), 64'(n_dresp), 64'(v.exp_ndresp));
        check($sformatf("v%0d_nilow", idx),  64'(n_ilow), 64'(v.exp_nilow));
        check($sformatf("v%0d_iresp", idx),  64'(instruction_response), 64'(v.exp_iresp));
        check($sformatf("v%0d_idata", idx),  64'(instruction_data), 64'(v.exp_idata));
        check($sformatf("v%0d_rdata", idx),  64'(read_data), 64'(v.exp_rdata));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n_hi;
        bit found;

        //          pc     rd    wr    daddr         wdata         cmd0              cmd1          ndr nil iresp idata           rdata
        vecs[0] = '{32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        rcmd(32'h00),     NONE,         0,  1,  1'b1, 32'h0000_0013, 32'h0};
        vecs[1] = '{32'h04, 1'b1, 1'b0, 32'h100,      32'h0,        rcmd(32'h100),    rcmd(32'h04), 1,  4,  1'b1, 32'h0010_0093, 32'hDEAD_BEEF};
        vecs[2] = '{32'h04, 1'b0, 1'b1, 32'h200,      32'h1111_1111, wcmd(32'h200),   NONE,         1,  0,  1'b1, 32'h0010_0093, 32'hDEAD_BEEF};
        vecs[3] = '{32'h04, 1'b1, 1'b0, 32'h200,      32'h0,        rcmd(32'h200),    NONE,         1,  0,  1'b1, 32'h0010_0093, 32'h1111_1111};
        vecs[4] = '{32'h10, 1'b0, 1'b0, 32'h0,        32'h0,        rcmd(32'h10),     NONE,         0,  1,  1'b1, 32'hA5A5_0010, 32'h1111_1111};
        vecs[5] = '{32'h10, 1'b0, 1'b1, 32'h10,       32'h0050_0513, wcmd(32'h10),    rcmd(32'h10), 1,  4,  1'b1, 32'h0050_0513, 32'h1111_1111};

        // Reset state
        repeat (3) tick();
        check("rst_mem_read",   64'(mem_if.mem_read), 64'(0));
        check("rst_mem_write",  64'(mem_if.mem_write), 64'(0));
        check("rst_mem_addr",   64'(mem_if.mem_address), 64'(0));
        check("rst_iresp",      64'(instruction_response), 64'(0));
        check("rst_idata",      64'(instruction_data), 64'(0));
        check("rst_rdata",      64'(read_data), 64'(0));
        check("rst_dresp",      64'(data_memory_response), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Continuous stores while a fetch of 0x20 waits: four stores, the fetch, then stores again.
        cmds.delete();
        pc    = 32'h20;
        wr    = 1'b1;
        daddr = 32'h300;
        wdata = 32'hCAFE_0000;
        repeat (20) tick();
        wr = 1'b0;
        check("starve_w0",     64'(cmd_at(0)), 64'(wcmd(32'h300)));
        check("starve_w1",     64'(cmd_at(1)), 64'(wcmd(32'h300)));
        check("starve_w2",     64'(cmd_at(2)), 64'(wcmd(32'h300)));
        check("starve_w3",     64'(cmd_at(3)), 64'(wcmd(32'h300)));
        check("starve_fetch",  64'(cmd_at(4)), 64'(rcmd(32'h20)));
        check("starve_resume", 64'(cmd_at(5)), 64'(wcmd(32'h300)));
        repeat (4) tick();
        check("starve_iresp",  64'(instruction_response), 64'(1));

        // Fetch of 0x08 in flight, PC jumps to 0x40 before the response.
        cmds.delete();
        lat = 3;
        pc  = 32'h08;
        tick();
        pc   = 32'h40;
        n_hi = 0;
        repeat (6) begin
            tick();
            if (instruction_response === 1'b1) n_hi++;
        end
        check("flush_no_stale_iresp", 64'(n_hi), 64'(0));
        repeat (4) tick();
        check("flush_cmd0",  64'(cmd_at(0)), 64'(rcmd(32'h08)));
        check("flush_cmd1",  64'(cmd_at(1)), 64'(rcmd(32'h40)));
        check("flush_iresp", 64'(instruction_response), 64'(1));
        check("flush_idata", 64'(instruction_data), 64'(32'h0000_0517));
        lat = 1;

        // Reset during DATA_WAIT, the abandoned access's response arrives afterwards.
        cmds.delete();
        mem_auto = 1'b0;
        rd       = 1'b1;
        daddr    = 32'h500;
        found    = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (mem_if.mem_read === 1'b1 && mem_if.mem_address == 32'h500) found = 1'b1;
        end
        check("rst2_load_issued", 64'(found), 64'(1));
        reset = 1'b1;
        rd    = 1'b0;
        @(posedge clk);
        #1 inject_req++;
        tick();
        check("rst2_mem_read",  64'(mem_if.mem_read), 64'(0));
        check("rst2_mem_write", 64'(mem_if.mem_write), 64'(0));
        check("rst2_mem_addr",  64'(mem_if.mem_address), 64'(0));
        check("rst2_mem_wdata", 64'(mem_if.mem_write_data), 64'(0));
        check("rst2_rdata",     64'(read_data), 64'(0));
        check("rst2_dresp",     64'(data_memory_response), 64'(0));
        check("rst2_iresp",     64'(instruction_response), 64'(0));
        check("rst2_idata",     64'(instruction_data), 64'(0));
        reset = 1'b0;
        tick();
        check("late_resp_dresp",    64'(data_memory_response), 64'(0));
        check("late_resp_rdata",    64'(read_data), 64'(0));
        check("late_resp_fetch",    64'(mem_if.mem_read), 64'(1));
        check("late_resp_fetch_pc", 64'(mem_if.mem_address), 64'(32'h40));
        mem_auto = 1'b1;
        n_dresp  = 0;
        repeat (4) tick();
        check("late_resp_no_dresp", 64'(n_dresp), 64'(0));
        check("after_rst_iresp",    64'(instruction_response), 64'(1));
        check("after_rst_idata",    64'(instruction_data), 64'(32'h0000_0517));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
